// File: rtl/mult_arbiter.sv
// Round-robin front end that time-shares one pipelined multiplier between several
// requesters and routes each product back to its issuer through a matching tag pipe.
module mult_arbiter #(
  parameter int WIDTH        = 6,
  parameter int REQUESTERS   = 4,
  parameter int MULT_LATENCY = 5,
  parameter int ID_WIDTH     = $clog2(REQUESTERS)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [REQUESTERS-1:0]            i_req_valid,
  output logic [REQUESTERS-1:0]            o_req_ready,
  input  logic [REQUESTERS*WIDTH-1:0]      i_req_in_1,
  input  logic [REQUESTERS*WIDTH-1:0]      i_req_in_2,
  output logic                             o_res_valid,
  output logic [ID_WIDTH-1:0]              o_res_id,
  output logic [2*WIDTH-1:0]               o_res_data,
  output logic                             o_busy,
  output logic                             o_mult_enable,
  output logic [WIDTH-1:0]                 o_mult_in_1,
  output logic [WIDTH-1:0]                 o_mult_in_2,
  input  logic [2*WIDTH-1:0]               i_mult_out
);

  logic [ID_WIDTH-1:0] r_last;
  logic                w_grant;
  logic [ID_WIDTH-1:0] w_grantId;
  logic [ID_WIDTH:0]   w_cand;
  logic [WIDTH-1:0]    w_op1;
  logic [WIDTH-1:0]    w_op2;

  logic [WIDTH-1:0]    r_multIn1;
  logic [WIDTH-1:0]    r_multIn2;

  logic [MULT_LATENCY:0] r_tagValid;
  logic [ID_WIDTH-1:0]   r_tagId [0:MULT_LATENCY];

  logic                r_resValid;
  logic [ID_WIDTH-1:0] r_resId;
  logic [2*WIDTH-1:0]  r_resData;

  // Search starts one past the last winner; w_cand is one bit wider so the wrap never overflows.
  always_comb begin
    w_grant   = 1'b0;
    w_grantId = '0;
    w_cand    = '0;
    for (int k = 1; k <= REQUESTERS; k++) begin
      w_cand = {1'b0, r_last} + (ID_WIDTH+1)'(k);
      if (w_cand >= (ID_WIDTH+1)'(REQUESTERS)) begin
        w_cand = w_cand - (ID_WIDTH+1)'(REQUESTERS);
      end
      if (!w_grant && i_req_valid[w_cand[ID_WIDTH-1:0]]) begin
        w_grant   = 1'b1;
        w_grantId = w_cand[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (w_grant) begin
      o_req_ready[w_grantId] = 1'b1;
    end
  end

  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (w_grant && (w_grantId == ID_WIDTH'(i))) begin
        w_op1 = i_req_in_1[i*WIDTH +: WIDTH];
        w_op2 = i_req_in_2[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last    <= ID_WIDTH'(REQUESTERS-1);
      r_multIn1 <= '0;
      r_multIn2 <= '0;
    end else begin
      if (w_grant) begin
        r_last <= w_grantId;
      end
      r_multIn1 <= w_op1;
      r_multIn2 <= w_op2;
    end
  end

  // Tag pipe is one stage deeper than the multiplier to cover the operand register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tagValid <= '0;
      for (int i = 0; i <= MULT_LATENCY; i++) begin
        r_tagId[i] <= '0;
      end
    end else begin
      r_tagValid <= {r_tagValid[MULT_LATENCY-1:0], w_grant};
      r_tagId[0] <= w_grantId;
      for (int i = 1; i <= MULT_LATENCY; i++) begin
        r_tagId[i] <= r_tagId[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_resValid <= 1'b0;
      r_resId    <= '0;
      r_resData  <= '0;
    end else begin
      r_resValid <= r_tagValid[MULT_LATENCY];
      if (r_tagValid[MULT_LATENCY]) begin
        r_resId   <= r_tagId[MULT_LATENCY];
        r_resData <= i_mult_out;
      end
    end
  end

  assign o_mult_in_1   = r_multIn1;
  assign o_mult_in_2   = r_multIn2;
  assign o_mult_enable = i_rst_n;
  assign o_res_valid   = r_resValid;
  assign o_res_id      = r_resId;
  assign o_res_data    = r_resData;
  assign o_busy        = (|r_tagValid) | r_resValid;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios plus random traffic, checked against a
// round-robin/queue reference model and a fixed-latency multiplier model.
module tb_mult_arbiter;

  localparam int W   = 6;
  localparam int N   = 4;
  localparam int L   = 5;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstN;
  logic [N-1:0]     reqValid;
  logic [N-1:0]     reqReady;
  logic [N*W-1:0]   reqIn1;
  logic [N*W-1:0]   reqIn2;
  logic             resValid;
  logic [IDW-1:0]   resId;
  logic [2*W-1:0]   resData;
  logic             busy;
  logic             multEnable;
  logic [W-1:0]     multIn1;
  logic [W-1:0]     multIn2;
  logic [2*W-1:0]   multOut;

  mult_arbiter #(.WIDTH(W), .REQUESTERS(N), .MULT_LATENCY(L)) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_req_valid(reqValid), .o_req_ready(reqReady),
    .i_req_in_1(reqIn1), .i_req_in_2(reqIn2),
    .o_res_valid(resValid), .o_res_id(resId), .o_res_data(resData),
    .o_busy(busy), .o_mult_enable(multEnable),
    .o_mult_in_1(multIn1), .o_mult_in_2(multIn2), .i_mult_out(multOut)
  );

  // Fixed-latency multiplier: product of cycle c appears in cycle c+L.
  logic [2*W-1:0] mulPipe [L];
  always_ff @(posedge clk) begin
    if (multEnable) begin
      mulPipe[0] <= {{W{1'b0}}, multIn1} * {{W{1'b0}}, multIn2};
      for (int i = 1; i < L; i++) mulPipe[i] <= mulPipe[i-1];
    end
  end
  assign multOut = mulPipe[L-1];

  typedef struct {int id; int data; int due;} expEntry_t;
  expEntry_t  expQ[$];
  int         mLast, nowCycle, heldId, heldData;
  bit         pend [N];
  logic [W-1:0] opA [N];
  logic [W-1:0] opB [N];
  int         checks = 0;
  int         errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      reqValid[i]        = pend[i];
      reqIn1[i*W +: W]   = opA[i];
      reqIn2[i*W +: W]   = opB[i];
    end
  endtask

  task automatic setReq(input int idx, input int a, input int b);
    pend[idx] = 1'b1;
    opA[idx]  = W'(a);
    opB[idx]  = W'(b);
  endtask

  task automatic clearModel();
    expQ.delete();
    mLast    = N - 1;
    heldId   = 0;
    heldData = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_resValid"}, 32'(resValid), 0);
    checkOutput({tag, "_resId"}, 32'(resId), 0);
    checkOutput({tag, "_resData"}, 32'(resData), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_multEn"}, 32'(multEnable), 0);
    checkOutput({tag, "_multIn1"}, 32'(multIn1), 0);
    checkOutput({tag, "_multIn2"}, 32'(multIn2), 0);
    checkOutput({tag, "_ready"}, 32'(reqReady), 0);
  endtask

  // One clock: check the grant mid-cycle, then the registered side after the edge.
  task automatic runCycle();
    int gId, expIn1, expIn2, expRv;
    applyStimulus();
    @(negedge clk);
    gId = -1;
    for (int k = 1; k <= N; k++) begin
      if (gId < 0 && pend[(mLast + k) % N]) gId = (mLast + k) % N;
    end
    checkOutput("ready", 32'(reqReady), (gId >= 0) ? (1 << gId) : 0);
    checkOutput("multEn", 32'(multEnable), 1);
    @(posedge clk);
    #1;
    nowCycle++;
    expIn1 = 0;
    expIn2 = 0;
    if (gId >= 0) begin
      expIn1 = int'(opA[gId]);
      expIn2 = int'(opB[gId]);
      expQ.push_back('{id: gId, data: expIn1 * expIn2, due: nowCycle + L + 1});
      mLast     = gId;
      pend[gId] = 1'b0;
    end
    checkOutput("multIn1", 32'(multIn1), expIn1);
    checkOutput("multIn2", 32'(multIn2), expIn2);
    checkOutput("busy", 32'(busy), (expQ.size() > 0) ? 1 : 0);
    expRv = 0;
    if (expQ.size() > 0 && expQ[0].due == nowCycle) begin
      heldId   = expQ[0].id;
      heldData = expQ[0].data;
      void'(expQ.pop_front());
      expRv = 1;
    end
    checkOutput("resValid", 32'(resValid), expRv);
    checkOutput("resId", 32'(resId), heldId);
    checkOutput("resData", 32'(resData), heldData);
  endtask

  task automatic drain();
    repeat (L + 3) runCycle();
    checkOutput("drainEmpty", expQ.size(), 0);
  endtask

  initial begin
    rstN     = 1'b0;
    nowCycle = 0;
    for (int i = 0; i < N; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end
    clearModel();
    applyStimulus();
    #2;
    checkResetOutputs("por");
    @(posedge clk);
    #3 rstN = 1'b1;

    $display("[TB] rotation");
    setReq(0, 10, 12); setReq(1, 60, 40); setReq(2, 63, 63); setReq(3, 0, 37);
    repeat (4) runCycle();
    setReq(0, 10, 12);
    runCycle();
    drain();

    $display("[TB] single request");
    setReq(2, 1, 10);
    runCycle();
    drain();

    $display("[TB] fairness");
    for (int c = 0; c < 8; c++) begin
      if (!pend[1]) setReq(1, $urandom_range(0, 63), $urandom_range(0, 63));
      if (!pend[3]) setReq(3, $urandom_range(0, 63), $urandom_range(0, 63));
      runCycle();
    end
    pend[1] = 1'b0;
    pend[3] = 1'b0;
    drain();

    $display("[TB] idle gaps");
    setReq(0, 7, 9);
    runCycle();
    repeat (3) runCycle();
    setReq(1, 33, 2);
    runCycle();
    drain();

    $display("[TB] reset mid-flight");
    for (int i = 0; i < 3; i++) setReq(i, 20 + i, 30 + i);
    repeat (3) runCycle();
    repeat (2) runCycle();
    #3 rstN = 1'b0;
    clearModel();
    applyStimulus();
    #1;
    checkResetOutputs("midReset");
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("inReset_resValid", 32'(resValid), 0);
    end
    #3 rstN = 1'b1;
    drain();
    for (int i = 0; i < N; i++) setReq(i, i + 1, 5);
    runCycle();
    checkOutput("firstAfterReset", mLast, 0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drain();

    $display("[TB] withdrawn request");
    setReq(0, 3, 3);
    setReq(1, 4, 4);
    runCycle();
    pend[1] = 1'b0;
    runCycle();
    setReq(2, 5, 5);
    setReq(1, 6, 6);
    runCycle();
    drain();

    $display("[TB] random traffic");
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          setReq(i, $urandom_range(0, 63), $urandom_range(0, 63));
        end else if (pend[i] && $urandom_range(0, 9) == 0) begin
          pend[i] = 1'b0;
        end
      end
      runCycle();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
